// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } csa_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width: enough headroom for MAX_OPS operands without wrap.
    function automatic int acc_w(input int width, input int max_ops);
        return width + clog2(max_ops);
    endfunction

    function automatic int num_chunks(input int acc, input int chunk);
        return (acc + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Row of full adders: three vectors in, sum and unshifted carry vectors out.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);

    assign s  = a ^ b ^ c;
    assign cy = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation, chunked final resolve.
// Optional CSA_ACC_SIGNED_EN: treat operands as two's complement (sign-extend).
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16,
    parameter int CHUNK   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [acc_w(WIDTH, MAX_OPS)-1:0]    sum,
    output logic                                ovf
);

    localparam int ACC_W = acc_w(WIDTH, MAX_OPS);
    localparam int R_C   = num_chunks(ACC_W, CHUNK);
    localparam int K_W   = clog2(R_C) + 1;
    localparam int CNT_W = clog2(MAX_OPS) + 1;

    csa_state_e        state_r, state_s;
    logic [ACC_W-1:0]  s_vec_r, c_vec_r, sum_r;
    logic [ACC_W-1:0]  x_s, csa_s_s, csa_c_s, mask_s, res_s, sum_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [K_W-1:0]    k_r;
    logic              chunk_c_r, ovf_r, in_ready_r, out_valid_r;
    logic              accept_s, last_chunk_s;
    logic [31:0]       lo_s;
    logic [CHUNK-1:0]  s_ch_s, c_ch_s;
    logic [CHUNK:0]    chunk_res_s;

`ifdef CSA_ACC_SIGNED_EN
    assign x_s = {{(ACC_W - WIDTH){in_data[WIDTH-1]}}, in_data};
`else
    assign x_s = {{(ACC_W - WIDTH){1'b0}}, in_data};
`endif

    assign accept_s     = in_valid && in_ready_r;
    assign last_chunk_s = (k_r == K_W'(R_C - 1));

    csa_3to2 #(.W(ACC_W)) u_csa (
        .a  (s_vec_r),
        .b  (c_vec_r),
        .c  (x_s),
        .s  (csa_s_s),
        .cy (csa_c_s)
    );

    // Chunk k of S+C+carry, merged into the partially resolved result.
    always_comb begin
        lo_s        = 32'(k_r) * 32'(CHUNK);
        s_ch_s      = CHUNK'(s_vec_r >> lo_s);
        c_ch_s      = CHUNK'(c_vec_r >> lo_s);
        chunk_res_s = {1'b0, s_ch_s} + {1'b0, c_ch_s} + {{CHUNK{1'b0}}, chunk_c_r};
        mask_s      = ACC_W'({CHUNK{1'b1}}) << lo_s;
        res_s       = ACC_W'(chunk_res_s[CHUNK-1:0]) << lo_s;
        sum_nxt_s   = (sum_r & ~mask_s) | res_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    state_s = in_last ? RESOLVE : ACCUM;
                end else begin
                    state_s = state_r;
                end
            end
            RESOLVE: begin
                if (last_chunk_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RESOLVE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            s_vec_r     <= '0;
            c_vec_r     <= '0;
            count_r     <= '0;
            k_r         <= '0;
            chunk_c_r   <= 1'b0;
            sum_r       <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE) || (state_s == ACCUM);
            out_valid_r <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        s_vec_r   <= x_s;
                        c_vec_r   <= '0;
                        count_r   <= CNT_W'(1);
                        ovf_r     <= 1'b0;
                        k_r       <= '0;
                        chunk_c_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        s_vec_r <= csa_s_s;
                        c_vec_r <= csa_c_s << 1;
                        // Count saturates once the limit is passed; ovf is sticky.
                        if (count_r == CNT_W'(MAX_OPS)) begin
                            ovf_r <= 1'b1;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                RESOLVE: begin
                    sum_r     <= sum_nxt_s;
                    chunk_c_r <= chunk_res_s[CHUNK];
                    k_r       <= k_r + K_W'(1);
                end
                DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    sum_r <= sum_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator (WIDTH=8, MAX_OPS=4, CHUNK=4).
module tb_csa_accumulator;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] sum;
    logic       ovf;

    int total = 0;
    int bad = 0;

    logic [7:0] cur_ops [8];

    typedef struct {
        int          n;
        logic [47:0] ops;
        logic [9:0]  s;
        logic        o;
    } vec_t;

    vec_t tbl [8];

    csa_accumulator #(.WIDTH(8), .MAX_OPS(4), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ext(input logic [7:0] d);
`ifdef CSA_ACC_SIGNED_EN
        return {{2{d[7]}}, d};
`else
        return {2'b00, d};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Sends cur_ops[0..n-1], waits for the result and checks latency, sum, ovf.
    task automatic run_txn(input int n, input string nm, input logic [9:0] exp_sum,
                           input logic exp_ovf, input bit gaps);
        int to;
        int lat;
        to = 0;
        @(negedge clk);
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        if (to >= 50) chk({nm, " idle_timeout"}, 32'(to), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = cur_ops[i];
            in_last  = (i == n - 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i != n - 1) @(negedge clk);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(LAT));
        chk({nm, " sum"}, 32'(sum), 32'(exp_sum));
        chk({nm, " ovf"}, 32'(ovf), 32'(exp_ovf));
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, " out_valid_drop"}, 32'(out_valid), 32'd0);
            chk({nm, " ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [9:0] m_sum;
        int         n;

        // Reset state
        #2;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

`ifndef CSA_ACC_SIGNED_EN
        tbl[0] = '{1, 48'h0000_0000_00FF, 10'h0FF, 1'b0};
        tbl[1] = '{4, 48'h0000_FFFF_FFFF, 10'h3FC, 1'b0};
        tbl[2] = '{5, 48'h0001_0101_0101, 10'h005, 1'b1};
        tbl[3] = '{2, 48'h0000_0000_0101, 10'h002, 1'b0};
        tbl[4] = '{1, 48'h0000_0000_0000, 10'h000, 1'b0};
        tbl[5] = '{6, 48'hFFFF_FFFF_FFFF, 10'h1FA, 1'b1};
        tbl[6] = '{2, 48'h0000_0000_55AA, 10'h0FF, 1'b0};
        tbl[7] = '{3, 48'h0000_0080_8080, 10'h180, 1'b0};
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 6; i++) cur_ops[i] = tbl[t].ops[i*8 +: 8];
            run_txn(tbl[t].n, $sformatf("vec%0d", t), tbl[t].s, tbl[t].o, 1'b0);
        end
`else
        cur_ops[0] = 8'h80;
        cur_ops[1] = 8'hFF;
        run_txn(2, "signed_neg", 10'h37F, 1'b0, 1'b0);
        cur_ops[0] = 8'h7F;
        cur_ops[1] = 8'h01;
        run_txn(2, "signed_pos", 10'h080, 1'b0, 1'b0);
`endif

        // Backpressure in DONE: outputs frozen, operand pulses ignored
        out_ready  = 1'b0;
        cur_ops[0] = 8'h12;
        cur_ops[1] = 8'h34;
        run_txn(2, "bp", 10'h046, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp sum", 32'(sum), 32'h046);
            chk("bp ovf", 32'(ovf), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset during the second RESOLVE cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(posedge clk);
        #1;
        in_data = 8'h44;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        chk("midrst sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst idle", 32'(in_ready), 32'd1);
        chk("midrst no_result", 32'(out_valid), 32'd0);
        cur_ops[0] = 8'h10;
        run_txn(1, "after_rst", 10'h010, 1'b0, 1'b0);

        // Randomized transactions against the arithmetic model
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 6);
            m_sum = 10'h000;
            for (int i = 0; i < n; i++) begin
                cur_ops[i] = 8'($urandom);
                m_sum = m_sum + ext(cur_ops[i]);
            end
            run_txn(n, $sformatf("rnd%0d", t), m_sum, (n > 4), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
Sequential multi-operand adder. It accepts a stream of WIDTH-bit operands, one per cycle, over a valid/ready handshake, and keeps a running total in redundant carry-save form (sum vector plus carry vector). On the operand flagged LAST it resolves the total through a multi-cycle chunked carry-propagate adder and presents the binary result over an output valid/ready handshake. It is the streaming, parametrised successor to the team's fixed three-operand carry-save adder, and is used by the multi-term FPU/ALU datapaths (dot products, mantissa sums).

Parameters:
WIDTH, 32, operand width in bits
MAX_OPS, 16, maximum operands per transaction before OVF is flagged; must be >= 2
CHUNK, 8, bits resolved per cycle by the final carry-propagate adder; must be 1..ACC_W

Ports:
CLK  input  1  clock; all state changes on the rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  operand valid
IN_READY  output  1  block can accept an operand
IN_DATA  input  WIDTH  operand
IN_LAST  input  1  marks the final operand of a transaction
OUT_VALID  output  1  result valid
OUT_READY  input  1  downstream accepts the result
SUM  output  ACC_W  resolved sum, where ACC_W = WIDTH + clog2(MAX_OPS)
OVF  output  1  more than MAX_OPS operands were accepted in this transaction

Behaviour:
- Reset (asynchronous, RST_N=0): state goes to IDLE; the sum vector, carry vector, operand count, chunk index, chunk carry, SUM and OVF all clear to 0. OUT_VALID=0 and IN_READY=0 while reset is asserted. A reset in any state, including mid-RESOLVE, abandons the transaction.
- Accept event: IN_VALID && IN_READY at a clock edge.
- States:
  - IDLE: IN_READY=1, OUT_VALID=0. On accept, load S=ext(IN_DATA), C=0, count=1, OVF=0. Go to RESOLVE if IN_LAST, else to ACCUM.
  - ACCUM: IN_READY=1. On accept, apply a 3:2 compression: S' = S ^ C ^ X and C' = maj(S,C,X) << 1, where X=ext(IN_DATA). All vectors are truncated to ACC_W bits. count increments. If count is already MAX_OPS, OVF sets and stays set for the transaction; accumulation continues with modulo-2^ACC_W wrap. Go to RESOLVE if IN_LAST.
  - RESOLVE: IN_READY=0. Each cycle adds chunk k (bits k*CHUNK up to min(ACC_W, (k+1)*CHUNK)-1) of S and C plus the registered chunk carry, and writes the result into SUM. The carry out of the top chunk is discarded. R = ceil(ACC_W/CHUNK) cycles. After the last chunk, go to DONE.
  - DONE: OUT_VALID=1 and IN_READY=0. SUM and OVF are held stable until OUT_READY=1 at an edge; then go to IDLE.
- Latency: OUT_VALID rises R clock edges after the edge that accepted IN_LAST. The throughput penalty is R+1 cycles minimum between transactions.
- ext(): zero-extension to ACC_W bits by default (see Optional Feature).
- A transaction with IN_LAST on its first operand is legal; SUM = ext(operand).
- IN_DATA and IN_LAST are ignored whenever IN_READY=0. IN_LAST presented with IN_VALID=0 has no effect.
- No output is combinationally dependent on any input.

Optional Feature:
CSA_ACC_SIGNED_EN.
- Defined: operands are two's complement and ext() sign-extends IN_DATA[WIDTH-1] to ACC_W bits. SUM is two's complement. OVF semantics are unchanged.
- Undefined: operands are unsigned and ext() zero-extends.

Decomposition:
- Package csa_pkg holds:
  - state enum {IDLE, ACCUM, RESOLVE, DONE}
  - constant function clog2
  - ACC_W and R computation functions
- One sub-module, csa_3to2: a parametrised-width row of full adders that takes three vectors and returns the sum vector and the unshifted carry vector. It is purely combinational; the shift and truncation are done by the parent.

Test Plan (WIDTH=8, MAX_OPS=4, CHUNK=4 → ACC_W=10, R=3):
- Single operand 8'hFF with IN_LAST → OUT_VALID 3 edges after accept, SUM=10'h0FF, OVF=0.
- Four operands 8'hFF on consecutive cycles, last with IN_LAST → SUM=10'h3FC, OVF=0, IN_READY=1 throughout accumulation.
- Five operands 8'h01, last with IN_LAST → SUM=10'h005, OVF=1; the next transaction of 2×8'h01 → SUM=10'h002, OVF=0.
- Backpressure: OUT_READY=0 for 5 cycles in DONE → SUM/OVF stable, IN_READY=0, IN_VALID pulses ignored; OUT_READY=1 → IDLE next cycle, IN_READY=1.
- RST_N pulsed low during the second RESOLVE cycle → SUM=0, OUT_VALID=0, state IDLE; a following single 8'h10 with IN_LAST → SUM=10'h010.
- CSA_ACC_SIGNED_EN defined: operands 8'h80 then 8'hFF (IN_LAST) → SUM=10'h37F (−129), OVF=0.
